seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 118 +++++++++++
 tb/tb_seq_divider.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor, one quotient bit per cycle.
// Define DIV_ZERO_CHECK_EN to short-circuit a zero divisor straight to DONE with dz set.
module seq_divider (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] nD,
    input  logic [3:0] dD,
    output logic [7:0] qQ,
    output logic [3:0] rQ,
    output logic       busy,
    output logic       done,
    output logic       dz
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t     state_q;
    logic [7:0] dividend_q;
    logic [3:0] divisor_q;
    logic [3:0] rem_q;
    logic [7:0] quot_q;
    logic [2:0] count_q;
    logic [7:0] q_q;
    logic [3:0] r_q;
    logic       busy_q;
    logic       done_q;
    logic       dz_q;

    logic [4:0] trial_d;
    logic [3:0] diff_d;
    logic       qbit_d;
    logic [3:0] rem_d;
    logic [7:0] quot_d;
    logic       zeroSkip;

`ifdef DIV_ZERO_CHECK_EN
    assign zeroSkip = (divisor_q == 4'd0);
`else
    assign zeroSkip = 1'b0;
`endif

    // The difference only matters when trial >= divisor, so it always fits in 4 bits.
    always_comb begin
        trial_d = {rem_q, dividend_q[7]};
        qbit_d  = (trial_d >= {1'b0, divisor_q});
        diff_d  = trial_d[3:0] - divisor_q;
        rem_d   = qbit_d ? diff_d : trial_d[3:0];
        quot_d  = {quot_q[6:0], qbit_d};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            dividend_q <= 8'h00;
            divisor_q  <= 4'h0;
            rem_q      <= 4'h0;
            quot_q     <= 8'h00;
            count_q    <= 3'd0;
            q_q        <= 8'h00;
            r_q        <= 4'h0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        dividend_q <= nD;
                        divisor_q  <= dD;
                        rem_q      <= 4'h0;
                        quot_q     <= 8'h00;
                        count_q    <= 3'd7;
                        busy_q     <= 1'b1;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    if (zeroSkip) begin
                        q_q     <= 8'hFF;
                        r_q     <= dividend_q[3:0];
                        dz_q    <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        dividend_q <= {dividend_q[6:0], 1'b0};
                        rem_q      <= rem_d;
                        quot_q     <= quot_d;
                        count_q    <= count_q - 3'd1;
                        if (count_q == 3'd0) begin
                            q_q     <= quot_d;
                            r_q     <= rem_d;
                            dz_q    <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign qQ   = q_q;
    assign rQ   = r_q;
    assign busy = busy_q;
    assign done = done_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a monitor checks each done pulse.
module tb_seq_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] nD;
    logic [3:0] dD;
    logic [7:0] qQ;
    logic [3:0] rQ;
    logic       busy;
    logic       done;
    logic       dz;

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
        int         cycle;
    } exp_t;

    exp_t       expQ[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         prevDone = -100;
    int         lastGap = 0;
    logic [7:0] lastQ = 8'h00;
    logic [3:0] lastR = 4'h0;

    seq_divider dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .nD    (nD),
        .dD    (dD),
        .qQ    (qQ),
        .rQ    (rQ),
        .busy  (busy),
        .done  (done),
        .dz    (dz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation, on time.
    always @(negedge clk) begin
        if (rst && done) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpectedDone: got done=1, expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("quotient", int'(qQ), int'(e.q));
                checkOutput("remainder", int'(rQ), int'(e.r));
                checkOutput("dzFlag", int'(dz), int'(e.z));
                checkOutput("latency", cyc, e.cycle);
                lastQ    = e.q;
                lastR    = e.r;
                lastGap  = cyc - prevDone;
                prevDone = cyc;
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] n, input logic [3:0] d);
        exp_t e;
        int   waited;
        int   lat;
        waited = 0;
        @(negedge clk);
        while (busy && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (busy) begin
            checkOutput("idleTimeout", int'(busy), 0);
            return;
        end
        start = 1'b1;
        nD    = n;
        dD    = d;
        @(posedge clk);
        #1;
`ifdef DIV_ZERO_CHECK_EN
        lat  = (d == 4'd0) ? 1 : 8;
        e.z  = (d == 4'd0);
`else
        lat  = 8;
        e.z  = 1'b0;
`endif
        if (d == 4'd0) begin
            e.q = 8'hFF;
            e.r = n[3:0];
        end else begin
            e.q = 8'(int'(n) / int'(d));
            e.r = 4'(int'(n) % int'(d));
        end
        e.cycle = cyc + lat;
        expQ.push_back(e);
        @(negedge clk);
        start = 1'b0;
        nD    = 8'($urandom);
        dD    = 4'($urandom);
    endtask

    // Wait for all outstanding results, then confirm the last result is held.
    task automatic drain();
        int waited;
        waited = 0;
        while (expQ.size() != 0 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (expQ.size() != 0) begin
            checkOutput("drainTimeout", expQ.size(), 0);
            expQ.delete();
        end
        repeat (3) @(negedge clk);
        checkOutput("holdQ", int'(qQ), int'(lastQ));
        checkOutput("holdR", int'(rQ), int'(lastR));
    endtask

    initial begin
        logic [7:0] bn[4] = '{8'd255, 8'd5, 8'd0, 8'd255};
        logic [3:0] bd[4] = '{4'd15, 4'd9, 4'd1, 4'd1};

        rst   = 1'b0;
        start = 1'b0;
        nD    = 8'h00;
        dD    = 4'h0;
        repeat (2) @(negedge clk);
        checkOutput("resetQ", int'(qQ), 0);
        checkOutput("resetR", int'(rQ), 0);
        checkOutput("resetBusy", int'(busy), 0);
        checkOutput("resetDone", int'(done), 0);
        checkOutput("resetDz", int'(dz), 0);
        rst = 1'b1;

        applyStimulus(8'd200, 4'd7);
        drain();

        for (int i = 0; i < 4; i++) begin
            applyStimulus(bn[i], bd[i]);
            drain();
        end

        applyStimulus(8'hA5, 4'd0);
        drain();

        // A start during CALC must be ignored while busy stays high.
        applyStimulus(8'd100, 4'd3);
        @(negedge clk);
        start = 1'b1;
        nD    = 8'd50;
        dD    = 4'd5;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("busyDuringCalc", int'(busy), 1);
            @(negedge clk);
        end
        drain();

        // Abort mid-calculation with a half-cycle reset pulse.
        applyStimulus(8'd200, 4'd7);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abortQ", int'(qQ), 0);
        checkOutput("abortR", int'(rQ), 0);
        checkOutput("abortBusy", int'(busy), 0);
        checkOutput("abortDone", int'(done), 0);
        checkOutput("abortDz", int'(dz), 0);
        expQ.delete();
        lastQ = 8'h00;
        lastR = 4'h0;
        #3;
        rst = 1'b1;
        repeat (12) @(negedge clk);
        applyStimulus(8'd9, 4'd2);
        drain();

        applyStimulus(8'd17, 4'd4);
        applyStimulus(8'd250, 4'd13);
        drain();
        checkOutput("backToBackGap", lastGap, 10);

        for (int i = 0; i < 40; i++) begin
            applyStimulus(8'($urandom), 4'($urandom_range(0, 15)));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
